// File: rtl/tone_burst_gen.sv
`default_nettype none
// ============================================================================
// tone_burst_gen: gates a synchronous tone into a decaying burst of N periods.
// Rev 1.0
// ============================================================================
module tone_burst_gen #(
  parameter int BURST_CYCLES = 16,
  parameter int AMP_BITS     = 8,
  parameter int AMP_INIT     = 255,
  parameter int DECAY_STEP   = 16
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                TONE_IN,
  input  logic                TRIGGER,
  output logic [AMP_BITS-1:0] SAMPLE_OUT,
  output logic                BUSY
);

  localparam int CYC_BITS = (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;
  localparam logic [CYC_BITS-1:0] CYC_LAST  = CYC_BITS'(BURST_CYCLES - 1);
  localparam logic [AMP_BITS-1:0] AMP_START = AMP_BITS'(AMP_INIT);
  localparam logic [AMP_BITS-1:0] AMP_STEP  = AMP_BITS'(DECAY_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [AMP_BITS-1:0] amp, amp_next;
  logic [CYC_BITS-1:0] cyc, cyc_next;
  logic                tone_q, trig_q;
  logic                rise, trig;
  logic [AMP_BITS:0]   amp_diff;

  assign rise = TONE_IN & ~tone_q;
  assign trig = TRIGGER & ~trig_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state  <= IDLE;
      amp    <= '0;
      cyc    <= '0;
      tone_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      state  <= state_next;
      amp    <= amp_next;
      cyc    <= cyc_next;
      tone_q <= TONE_IN;
      trig_q <= TRIGGER;
    end
  end

  always_comb begin
    state_next = state;
    amp_next   = amp;
    cyc_next   = cyc;
    // Extra MSB of the difference flags underflow so the decay clamps at 0.
    amp_diff   = {1'b0, amp} - {1'b0, AMP_STEP};
    case (state)
      IDLE: begin
        if (trig) state_next = ARM;
      end
      ARM: begin
        if (rise) begin
          state_next = PLAY;
          amp_next   = AMP_START;
          cyc_next   = '0;
        end
      end
      PLAY: begin
        if (trig) begin
          state_next = ARM;
          amp_next   = AMP_START;
          cyc_next   = '0;
        end else if (rise) begin
          if (cyc == CYC_LAST) begin
            state_next = IDLE;
          end else begin
            cyc_next = cyc + 1'b1;
            amp_next = amp_diff[AMP_BITS] ? '0 : amp_diff[AMP_BITS-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign SAMPLE_OUT = (state == PLAY && tone_q) ? amp : '0;
  assign BUSY       = (state == ARM) || (state == PLAY);

endmodule
`default_nettype wire
